reg_scoreboard: RTL and testbench
=================================

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 Parameter ADDR_W, default 5, register-address width.
REQ-002 Parameter NREG, default 2**ADDR_W, number of tracked registers.
REQ-003 Parameter ZERO_REG, default 31, hard-wired zero register index, never tracked.
REQ-004 Clocking SHALL be one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 iss_en  input  1  instruction issue request.
REQ-008 iss_rd  input  ADDR_W  destination register of issuing instruction.
REQ-009 rs1_en / rs2_en  input  1 each  source operand used.
REQ-010 rs1 / rs2  input  ADDR_W each  source register addresses.
REQ-011 wb_en  input  1  writeback completes this cycle.
REQ-012 wb_rd  input  ADDR_W  writeback destination register.
REQ-013 iss_accept  output  1  issue accepted this cycle (combinational).
REQ-014 stall  output  1  issue requested but blocked (combinational).
REQ-015 rs1_busy / rs2_busy  output  1 each  source has a pending write (combinational).
REQ-016 busy_vec  output  NREG  registered pending-write bit per register.
REQ-017 busy_cnt  output  ADDR_W+1  registered population count of busy_vec.
REQ-018 err  output  1  sticky protocol-error flag, registered.

Function
REQ-019 Issue and writeback addresses SHALL each be decoded to an NREG-bit one-hot vector, all-zero when the respective enable is low or the address equals ZERO_REG or is >= NREG.
REQ-020 wb_hit(x) SHALL be wb_en & (wb_rd == x) & (x != ZERO_REG).
REQ-021 rsN_busy SHALL be rsN_en & busy_vec[rsN] & ~wb_hit(rsN); 0 when rsN == ZERO_REG (writeback bypass, same cycle).
REQ-022 rd_clear SHALL be iss_rd == ZERO_REG | ~busy_vec[iss_rd] | wb_hit(iss_rd) (WAW check with bypass).
REQ-023 iss_accept SHALL be iss_en & rd_clear & ~rs1_busy & ~rs2_busy; stall SHALL be iss_en & ~iss_accept.
REQ-024 Next busy_vec SHALL be (busy_vec & ~wb_onehot) | (iss_onehot gated by iss_accept); set wins when both target the same register in one cycle.
REQ-025 A set or clear SHALL become visible on busy_vec and busy_cnt exactly one cycle after the accepting/writeback edge.
REQ-026 busy_cnt SHALL equal popcount of busy_vec at all times, never exceeding NREG-1 (ZERO_REG excluded).
REQ-027 err SHALL set on the edge following wb_en with wb_rd != ZERO_REG and busy_vec[wb_rd] == 0, or wb_rd >= NREG; err stays 1 until reset.
REQ-028 Writeback to ZERO_REG SHALL be ignored without setting err.
REQ-029 Issue with iss_en low SHALL not alter state; stall SHALL be 0.
REQ-030 Outputs SHALL have no dependence on any state other than busy_vec and err.

Reset
REQ-031 On reset assertion, busy_vec, busy_cnt and err SHALL go to 0 immediately, independent of clk.
REQ-032 Reset asserted mid-operation SHALL discard all pending writes; iss_accept/stall evaluate against the cleared state.
REQ-033 After reset deassertion, the first rising edge SHALL honour issue and writeback normally.

Verification
REQ-034 Reset, iss_en=1 iss_rd=3 rs unused -> iss_accept=1 same cycle; next cycle busy_vec=0x00000008, busy_cnt=1.
REQ-035 busy[3]=1, issue rs1_en=1 rs1=3 wb_en=0 -> rs1_busy=1, stall=1, busy_vec unchanged; repeat with wb_en=1 wb_rd=3 -> rs1_busy=0, iss_accept=1.
REQ-036 busy[5]=1, iss_rd=5 with wb_en=1 wb_rd=5 same cycle -> iss_accept=1; next cycle busy[5]=1 (set wins), busy_cnt unchanged.
REQ-037 iss_rd=31 repeatedly -> iss_accept=1, busy_vec stays 0; wb_rd=31 -> err stays 0.
REQ-038 busy_vec=0, wb_en=1 wb_rd=7 -> err=1 next cycle, remains 1 until reset pulse, then 0.
REQ-039 Issue regs 0..30 back-to-back -> busy_cnt reaches 31; assert reset asynchronously mid-clock -> busy_vec=0, busy_cnt=0 before next edge.

Source files
------------

// File: rtl/reg_scoreboard.sv
// Register scoreboard: one pending-write bit per architectural register, with same-cycle
// writeback bypass on RAW/WAW checks and a sticky flag for writebacks nothing was waiting on.
module reg_scoreboard #(
    parameter int ADDR_W   = 5,
    parameter int NREG     = 2**ADDR_W,
    parameter int ZERO_REG = 31
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_rd,
    input  logic              rs1_en,
    input  logic [ADDR_W-1:0] rs1,
    input  logic              rs2_en,
    input  logic [ADDR_W-1:0] rs2,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_rd,
    output logic              iss_accept,
    output logic              stall,
    output logic              rs1_busy,
    output logic              rs2_busy,
    output logic [NREG-1:0]   busy_vec,
    output logic [ADDR_W:0]   busy_cnt,
    output logic              err
);

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return 32'(a) == ZERO_REG;
    endfunction

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return 32'(a) < NREG;
    endfunction

    function automatic logic [NREG-1:0] decode(input logic en, input logic [ADDR_W-1:0] a);
        logic [NREG-1:0] oh;
        oh = '0;
        for (int i = 0; i < NREG; i++)
            if (en && !is_zero(a) && in_range(a) && (32'(a) == i))
                oh[i] = 1'b1;
        return oh;
    endfunction

    // Out-of-range addresses read as "not busy" rather than indexing past the vector.
    function automatic logic bit_of(input logic [NREG-1:0] v, input logic [ADDR_W-1:0] a);
        logic b;
        b = 1'b0;
        for (int i = 0; i < NREG; i++)
            if (32'(a) == i)
                b = v[i];
        return b;
    endfunction

    function automatic logic [ADDR_W:0] popcount(input logic [NREG-1:0] v);
        logic [ADDR_W:0] c;
        c = '0;
        for (int i = 0; i < NREG; i++)
            c = c + (ADDR_W+1)'(v[i]);
        return c;
    endfunction

    function automatic logic wb_hit(input logic [ADDR_W-1:0] x);
        return wb_en && (wb_rd == x) && !is_zero(x);
    endfunction

    logic [NREG-1:0]  iss_onehot;
    logic [NREG-1:0]  wb_onehot;
    logic [NREG-1:0]  busy_nxt;
    logic             rd_clear;
    logic             wb_bad;

    always_comb begin
        rs1_busy   = rs1_en && !is_zero(rs1) && bit_of(busy_vec, rs1) && !wb_hit(rs1);
        rs2_busy   = rs2_en && !is_zero(rs2) && bit_of(busy_vec, rs2) && !wb_hit(rs2);
        rd_clear   = is_zero(iss_rd) || !bit_of(busy_vec, iss_rd) || wb_hit(iss_rd);
        iss_accept = iss_en && rd_clear && !rs1_busy && !rs2_busy;
        stall      = iss_en && !iss_accept;
        iss_onehot = decode(iss_accept, iss_rd);
        wb_onehot  = decode(wb_en, wb_rd);
        // Issue set is applied after the writeback clear so a same-cycle rewrite stays pending.
        busy_nxt   = (busy_vec & ~wb_onehot) | iss_onehot;
        wb_bad     = wb_en && !is_zero(wb_rd) && (!in_range(wb_rd) || !bit_of(busy_vec, wb_rd));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_vec <= '0;
            busy_cnt <= '0;
            err      <= 1'b0;
        end else begin
            busy_vec <= busy_nxt;
            busy_cnt <= popcount(busy_nxt);
            err      <= err | wb_bad;
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: a vector table for single-cycle behaviour plus
// hand-written sequences for reset timing and filling every register.
module tb_reg_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic        iss_en, rs1_en, rs2_en, wb_en;
    logic [4:0]  iss_rd, rs1, rs2, wb_rd;
    logic        iss_accept, stall, rs1_busy, rs2_busy;
    logic [31:0] busy_vec;
    logic [5:0]  busy_cnt;
    logic        err;

    int n_cmp  = 0;
    int n_fail = 0;

    reg_scoreboard dut (
        .clk(clk), .reset(reset),
        .iss_en(iss_en), .iss_rd(iss_rd),
        .rs1_en(rs1_en), .rs1(rs1), .rs2_en(rs2_en), .rs2(rs2),
        .wb_en(wb_en), .wb_rd(wb_rd),
        .iss_accept(iss_accept), .stall(stall),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .busy_vec(busy_vec), .busy_cnt(busy_cnt), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       ie;  logic [4:0] ird;
        logic       r1e; logic [4:0] r1;
        logic       r2e; logic [4:0] r2;
        logic       we;  logic [4:0] wrd;
        logic       acc, stl, b1, b2;
        logic [31:0] bv; logic [5:0] cnt; logic er;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic ie, logic [4:0] ird, logic r1e, logic [4:0] r1,
                                logic r2e, logic [4:0] r2, logic we, logic [4:0] wrd,
                                logic acc, logic stl, logic b1, logic b2,
                                logic [31:0] bv, logic [5:0] cnt, logic er);
        vec_t v;
        v.ie = ie; v.ird = ird; v.r1e = r1e; v.r1 = r1; v.r2e = r2e; v.r2 = r2;
        v.we = we; v.wrd = wrd; v.acc = acc; v.stl = stl; v.b1 = b1; v.b2 = b2;
        v.bv = bv; v.cnt = cnt; v.er = er;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        iss_en = 0; iss_rd = 0; rs1_en = 0; rs1 = 0; rs2_en = 0; rs2 = 0; wb_en = 0; wb_rd = 0;
    endtask

    initial begin
        // ie ird r1e r1 r2e r2 we wrd | acc stl b1 b2 | busy_vec cnt err (after edge)
        tbl.push_back(mk(1, 3, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 32'h0000_0008, 1, 0));
        tbl.push_back(mk(1, 4, 1, 3, 0, 0, 0, 0,   0, 1, 1, 0, 32'h0000_0008, 1, 0));
        tbl.push_back(mk(1, 4, 1, 3, 0, 0, 1, 3,   1, 0, 0, 0, 32'h0000_0010, 1, 0));
        tbl.push_back(mk(1, 5, 0, 0, 1, 4, 0, 0,   0, 1, 0, 1, 32'h0000_0010, 1, 0));
        tbl.push_back(mk(1, 5, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 32'h0000_0030, 2, 0));
        tbl.push_back(mk(1, 5, 0, 0, 0, 0, 1, 5,   1, 0, 0, 0, 32'h0000_0030, 2, 0));
        tbl.push_back(mk(1, 4, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 32'h0000_0030, 2, 0));
        tbl.push_back(mk(0, 6, 1, 5, 0, 0, 0, 0,   0, 0, 1, 0, 32'h0000_0030, 2, 0));
        tbl.push_back(mk(1, 31, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 32'h0000_0030, 2, 0));
        tbl.push_back(mk(1, 31, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 32'h0000_0030, 2, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 31,  0, 0, 0, 0, 32'h0000_0030, 2, 0));
        tbl.push_back(mk(1, 6, 1, 31, 1, 4, 0, 0,  0, 1, 0, 1, 32'h0000_0030, 2, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 4,   0, 0, 0, 0, 32'h0000_0020, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 5,   0, 0, 0, 0, 32'h0000_0000, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 7,   0, 0, 0, 0, 32'h0000_0000, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 32'h0000_0000, 0, 1));

        // Reset state
        idle_inputs();
        reset = 1;
        #3;
        chk("rst busy_vec", busy_vec, 0);
        chk("rst busy_cnt", 32'(busy_cnt), 0);
        chk("rst err", 32'(err), 0);
        chk("rst stall", 32'(stall), 0);
        @(posedge clk); #1;
        reset = 0;

        // Table-driven vectors, applied back-to-back from the reset state
        for (int k = 0; k < tbl.size(); k++) begin
            iss_en = tbl[k].ie;  iss_rd = tbl[k].ird;
            rs1_en = tbl[k].r1e; rs1 = tbl[k].r1;
            rs2_en = tbl[k].r2e; rs2 = tbl[k].r2;
            wb_en  = tbl[k].we;  wb_rd = tbl[k].wrd;
            #1;
            chk($sformatf("v%0d iss_accept", k), 32'(iss_accept), 32'(tbl[k].acc));
            chk($sformatf("v%0d stall", k), 32'(stall), 32'(tbl[k].stl));
            chk($sformatf("v%0d rs1_busy", k), 32'(rs1_busy), 32'(tbl[k].b1));
            chk($sformatf("v%0d rs2_busy", k), 32'(rs2_busy), 32'(tbl[k].b2));
            @(posedge clk); #1;
            chk($sformatf("v%0d busy_vec", k), busy_vec, tbl[k].bv);
            chk($sformatf("v%0d busy_cnt", k), 32'(busy_cnt), 32'(tbl[k].cnt));
            chk($sformatf("v%0d err", k), 32'(err), 32'(tbl[k].er));
        end
        idle_inputs();

        // Sticky err cleared only by an asynchronous reset pulse
        #2 reset = 1;
        #1;
        chk("errpulse err", 32'(err), 0);
        @(posedge clk); #1;
        reset = 0;
        @(posedge clk); #1;
        chk("errpulse err after", 32'(err), 0);

        // Fill registers 0..30 back-to-back
        for (int r = 0; r < 31; r++) begin
            iss_en = 1; iss_rd = 5'(r);
            #1;
            chk($sformatf("fill%0d iss_accept", r), 32'(iss_accept), 1);
            @(posedge clk); #1;
        end
        chk("fill busy_vec", busy_vec, 32'h7FFF_FFFF);
        chk("fill busy_cnt", 32'(busy_cnt), 31);

        // Everything busy: a RAW on r3 stalls; async reset mid-clock then frees it
        iss_en = 1; iss_rd = 3; rs1_en = 1; rs1 = 3;
        #1;
        chk("full stall", 32'(stall), 1);
        chk("full rs1_busy", 32'(rs1_busy), 1);
        #1 reset = 1;
        #1;
        chk("midrst busy_vec", busy_vec, 0);
        chk("midrst busy_cnt", 32'(busy_cnt), 0);
        chk("midrst rs1_busy", 32'(rs1_busy), 0);
        chk("midrst iss_accept", 32'(iss_accept), 1);
        chk("midrst stall", 32'(stall), 0);
        @(posedge clk); #1;
        chk("inrst busy_vec", busy_vec, 0);
        reset = 0;
        #1;
        chk("postrst iss_accept", 32'(iss_accept), 1);
        @(posedge clk); #1;
        chk("postrst busy_vec", busy_vec, 32'h0000_0008);
        chk("postrst busy_cnt", 32'(busy_cnt), 1);
        chk("postrst err", 32'(err), 0);

        // Writeback of an out-of-order register not pending flags err even with other bits busy
        idle_inputs();
        wb_en = 1; wb_rd = 9;
        @(posedge clk); #1;
        chk("wb9 err", 32'(err), 1);
        chk("wb9 busy_vec", busy_vec, 32'h0000_0008);
        idle_inputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
